// File: rtl/mealy_pkg.sv
// Shared definitions for the Mealy serial-pattern detector: pattern length
// limits, the transition classification enum and the constant functions that
// build the KMP transition tables at elaboration.
package mealy_pkg;

   localparam int PATTERN_LEN_MIN = 2;
   localparam int PATTERN_LEN_MAX = 16;

   typedef enum logic [1:0] {
      STEP_HOLD     = 2'd0,
      STEP_ADVANCE  = 2'd1,
      STEP_MATCH    = 2'd2,
      STEP_FALLBACK = 2'd3
   } step_e;

   function automatic bit len_ok(input int len);
      return (len >= PATTERN_LEN_MIN) && (len <= PATTERN_LEN_MAX);
   endfunction

   // Longest pattern prefix (strictly shorter than the pattern) that is a
   // suffix of the string formed by the first 'state' pattern bits followed
   // by 'b'. Pattern bit [len-1] is the first bit received.
   function automatic int kmp_next(input logic [15:0] pattern, input int len,
                                   input int state, input logic b);
      int   best;
      int   pos;
      logic ok;
      logic sb;
      best = 0;
      for (int j = 1; j < PATTERN_LEN_MAX; j++) begin
         if (j < len && j <= state + 1) begin
            ok = 1'b1;
            for (int m = 0; m < PATTERN_LEN_MAX; m++) begin
               if (m < j) begin
                  pos = state + 1 - j + m;
                  sb  = (pos == state) ? b : pattern[4'(len - 1 - pos)];
                  if (sb != pattern[4'(len - 1 - m)]) ok = 1'b0;
               end
            end
            if (ok) best = j;
         end
      end
      return best;
   endfunction

   // Longest proper prefix of the whole pattern that is also its suffix:
   // the state to resume from after a completed overlapping match.
   function automatic int kmp_fail(input logic [15:0] pattern, input int len);
      return kmp_next(pattern, len, len - 1, pattern[0]);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses, holds at all-ones, clr/reset to 0.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;

   // Count register: reset and clear dominate, increment stops at full scale.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (inc && (count_q != {W{1'b1}})) begin
         count_q <= count_q + W'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy serial-pattern detector with saturating match counter.
// Optional macro MEALY_REG_OUT_EN: when defined, match is passed through a
// flop (one cycle later, glitch-free); otherwise match is the raw Mealy output.
module mealy_seq_detector
   import mealy_pkg::*;
#(
   parameter int                     PATTERN_LEN = 4,
   parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
   parameter bit                     OVERLAP     = 1'b1,
   parameter int                     CNT_W       = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   input  logic                           in_bit,
   input  logic                           clear,
   output logic                           match,
   output logic [CNT_W-1:0]               match_count,
   output logic [$clog2(PATTERN_LEN)-1:0] state_dbg
);

   localparam int          SW         = $clog2(PATTERN_LEN);
   localparam logic [15:0] PAT16      = 16'(PATTERN);
   localparam logic [SW-1:0] LAST_ST  = SW'(PATTERN_LEN - 1);
   localparam logic [SW-1:0] MATCH_ST = OVERLAP ? SW'(kmp_fail(PAT16, PATTERN_LEN)) : '0;

   if (!len_ok(PATTERN_LEN)) begin : g_bad_len
      $error("mealy_seq_detector: PATTERN_LEN out of range 2..16");
   end

   // Per-state lookup: the bit that extends Sk, and the fallback state for
   // each input bit value when it does not.
   logic [PATTERN_LEN-1:0]         want_tbl;
   logic [PATTERN_LEN-1:0][SW-1:0] fb0_tbl;
   logic [PATTERN_LEN-1:0][SW-1:0] fb1_tbl;

   for (genvar k = 0; k < PATTERN_LEN; k++) begin : g_tbl
      assign want_tbl[k] = PATTERN[PATTERN_LEN-1-k];
      assign fb0_tbl[k]  = SW'(kmp_next(PAT16, PATTERN_LEN, k, 1'b0));
      assign fb1_tbl[k]  = SW'(kmp_next(PAT16, PATTERN_LEN, k, 1'b1));
   end

   logic [SW-1:0] state_q;
   logic [SW-1:0] state_d;
   logic          match_d;
   step_e         step;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

   // Classify the accepted bit, then derive next state and the Mealy match.
   always_comb begin
      step    = STEP_HOLD;
      state_d = state_q;
      match_d = 1'b0;

      if (!reset && !clear && in_valid) begin
         if (in_bit == want_tbl[state_q]) begin
            step = (state_q == LAST_ST) ? STEP_MATCH : STEP_ADVANCE;
         end else begin
            step = STEP_FALLBACK;
         end
      end

      case (step)
         STEP_ADVANCE:  state_d = state_q + SW'(1);
         STEP_MATCH: begin
            state_d = MATCH_ST;
            match_d = 1'b1;
         end
         STEP_FALLBACK: state_d = in_bit ? fb1_tbl[state_q] : fb0_tbl[state_q];
         default:       state_d = clear ? '0 : state_q;
      endcase
   end

   sat_counter #(
      .W(CNT_W)
   ) u_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (match_d),
      .clr  (clear),
      .count(match_count)
   );

`ifdef MEALY_REG_OUT_EN
   logic match_q;

   // Output flop removes combinational glitches on match.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         match_q <= 1'b0;
      end else begin
         match_q <= match_d;
      end
   end

   assign match = match_q;
`else
   assign match = match_d;
`endif

   assign state_dbg = state_q;

endmodule
